hnf_txreq_lcrdq: RTL and testbench

HNF request-issue queue feeding the TXREQ channel towards the SNF. Accepts request flits (e.g. ReadNoSnp) from the HNF pipeline through a valid/ready handshake and buffers them in a FIFO. It counts L-credits returned on TXREQLCRDV and drives TXREQFLITPEND/TXREQFLITV/TXREQFLIT to the CHI link, so that a flit is only sent while a credit is held. It sits directly upstream of the TXREQ link interface and downstream of the HNF request pipeline.

---
 rtl/hnf_txreq_lcrdq.sv | 133 +++++++++++++
 tb/tb_hnf_txreq_lcrdq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hnf_txreq_lcrdq.sv
// HNF TXREQ issue queue: buffers request flits and sends them on the CHI link only while an L-credit is held.
// Optional build macro HNF_TXREQ_CRD_ERR_EN enables the sticky credit-overflow error flag.

package hnf_txreq_pkg;
    typedef struct packed {
        logic [5:0]  opcode;
        logic [47:0] addr;
        logic [11:0] txnid;
    } reqflit_t;

    localparam logic [5:0] OP_READNOSNP = 6'h04;
endpackage

module hnf_txreq_lcrdq
    import hnf_txreq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_CRD = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  reqflit_t   req_flit,
    output logic       req_ready,
    output reqflit_t   TXREQFLIT,
    output logic       TXREQFLITV,
    output logic       TXREQFLITPEND,
    input  logic       TXREQLCRDV,
    output logic [3:0] crd_cnt,
    output logic       crd_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reqflit_t            mem_q [DEPTH];
    reqflit_t            mem_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [3:0]          crd_q, crd_d;
    logic                pend_q, pend_d;
    logic                flitv_q, flitv_d;
    reqflit_t            flit_q, flit_d;
    logic                push_s, send_s, ovf_s;

    assign req_ready     = (count_q != CNT_W'(DEPTH));
    assign TXREQFLIT     = flit_q;
    assign TXREQFLITV    = flitv_q;
    assign TXREQFLITPEND = pend_q;
    assign crd_cnt       = crd_q;

    // Next-state for FIFO, credit counter and link outputs.
    always_comb begin
        push_s  = req_valid & req_ready;
        send_s  = pend_q & (count_q != {CNT_W{1'b0}}) & (crd_q != 4'd0);
        ovf_s   = TXREQLCRDV & ~send_s & (crd_q == 4'(MAX_CRD));

        mem_d   = mem_q;
        tail_d  = tail_q;
        if (push_s) begin
            mem_d[tail_q] = req_flit;
            tail_d        = tail_q + PTR_W'(1);
        end else begin
            tail_d        = tail_q;
        end

        head_d  = send_s ? head_q + PTR_W'(1) : head_q;
        count_d = count_q + CNT_W'(push_s) - CNT_W'(send_s);
        pend_d  = (count_d != {CNT_W{1'b0}});
        flitv_d = send_s;
        flit_d  = send_s ? mem_q[head_q] : flit_q;

        // Credit return and consumption cancel; saturate at MAX_CRD.
        if (ovf_s) begin
            crd_d = crd_q;
        end else if (TXREQLCRDV && !send_s) begin
            crd_d = crd_q + 4'd1;
        end else if (!TXREQLCRDV && send_s) begin
            crd_d = crd_q - 4'd1;
        end else begin
            crd_d = crd_q;
        end
    end

    // Control state with synchronous reset; flushes queue and credits.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            crd_q   <= 4'd0;
            pend_q  <= 1'b0;
            flitv_q <= 1'b0;
            flit_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            crd_q   <= crd_d;
            pend_q  <= pend_d;
            flitv_q <= flitv_d;
            flit_q  <= flit_d;
        end
    end

    // FIFO storage; contents are only meaningful between head and tail.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

`ifdef HNF_TXREQ_CRD_ERR_EN
    logic crd_err_q, crd_err_d;

    // Sticky overflow flag.
    always_comb begin
        crd_err_d = crd_err_q | ovf_s;
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            crd_err_q <= 1'b0;
        end else begin
            crd_err_q <= crd_err_d;
        end
    end

    assign crd_err = crd_err_q;
`else
    assign crd_err = 1'b0;
`endif

endmodule

// File: tb/tb_hnf_txreq_lcrdq.sv
// Directed table-driven bench for hnf_txreq_lcrdq plus hand sequences for saturation and back-to-back sends.
module tb_hnf_txreq_lcrdq;
    import hnf_txreq_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    reqflit_t   req_flit = '0;
    logic       req_ready;
    reqflit_t   TXREQFLIT;
    logic       TXREQFLITV;
    logic       TXREQFLITPEND;
    logic       TXREQLCRDV = 1'b0;
    logic [3:0] crd_cnt;
    logic       crd_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_row = 0;

`ifdef HNF_TXREQ_CRD_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    hnf_txreq_lcrdq #(.DEPTH(4), .MAX_CRD(15)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_flit(req_flit),
        .req_ready(req_ready), .TXREQFLIT(TXREQFLIT), .TXREQFLITV(TXREQFLITV),
        .TXREQFLITPEND(TXREQFLITPEND), .TXREQLCRDV(TXREQLCRDV),
        .crd_cnt(crd_cnt), .crd_err(crd_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] txn;
        logic       lc;
        logic       e_rdy;
        logic       e_v;
        logic       e_p;
        logic [3:0] e_crd;
        logic [7:0] e_txn;
    } vec_t;

    function automatic reqflit_t mk_flit(input logic [7:0] txn);
        reqflit_t f;
        f.opcode = OP_READNOSNP;
        f.addr   = 48'h0000_0000_1000 ^ (48'(txn ^ 8'd5) << 6);
        f.txnid  = 12'(txn);
        return f;
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, cur_row, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] t, input logic l);
        reset      = r;
        req_valid  = v;
        req_flit   = mk_flit(t);
        TXREQLCRDV = l;
        @(posedge clock);
        #1;
        cur_row++;
    endtask

    vec_t tbl[$];

    function automatic vec_t R(input logic rst, input logic vld, input logic [7:0] txn, input logic lc,
                               input logic rdy, input logic v, input logic p, input logic [3:0] crd,
                               input logic [7:0] etxn);
        vec_t x;
        x.rst = rst; x.vld = vld; x.txn = txn; x.lc = lc;
        x.e_rdy = rdy; x.e_v = v; x.e_p = p; x.e_crd = crd; x.e_txn = etxn;
        return x;
    endfunction

    initial begin
        // A: three credits, one ReadNoSnp, 2-cycle latency
        tbl.push_back(R(1,0,0,0, 1,0,0,0,0));
        tbl.push_back(R(0,0,0,1, 1,0,0,1,0));
        tbl.push_back(R(0,0,0,1, 1,0,0,2,0));
        tbl.push_back(R(0,0,0,1, 1,0,0,3,0));
        tbl.push_back(R(0,1,5,0, 1,0,1,3,0));
        tbl.push_back(R(0,0,0,0, 1,1,0,2,5));
        tbl.push_back(R(0,0,0,0, 1,0,0,2,0));
        // B: fill with no credits, then drain one flit per spaced credit
        tbl.push_back(R(1,0,0,0, 1,0,0,0,0));
        tbl.push_back(R(0,1,1,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,2,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,3,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,4,0, 0,0,1,0,0));
        tbl.push_back(R(0,0,0,0, 0,0,1,0,0));
        for (int k = 1; k <= 4; k++) begin
            tbl.push_back(R(0,0,0,1, (k != 1) ? 1'b1 : 1'b0, 0,1,1,0));
            tbl.push_back(R(0,0,0,0, 1,1,(k != 4) ? 1'b1 : 1'b0,0,8'(k)));
            tbl.push_back(R(0,0,0,0, 1,0,(k != 4) ? 1'b1 : 1'b0,0,0));
        end
        // E: full queue, held req_valid, one credit; then credit+send at crd==1
        tbl.push_back(R(0,1,1,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,2,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,3,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,4,0, 0,0,1,0,0));
        tbl.push_back(R(0,1,5,1, 0,0,1,1,0));
        tbl.push_back(R(0,1,5,0, 1,1,1,0,1));
        tbl.push_back(R(0,1,5,0, 0,0,1,0,0));
        tbl.push_back(R(0,0,0,1, 0,0,1,1,0));
        tbl.push_back(R(0,0,0,1, 1,1,1,1,2));
        tbl.push_back(R(0,0,0,0, 1,1,1,0,3));
        tbl.push_back(R(0,0,0,1, 1,0,1,1,0));
        tbl.push_back(R(0,0,0,0, 1,1,1,0,4));
        tbl.push_back(R(0,0,0,1, 1,0,1,1,0));
        tbl.push_back(R(0,0,0,0, 1,1,0,0,5));
        // F: reset with queued flits and a credit arriving; nothing stale afterwards
        tbl.push_back(R(1,0,0,0, 1,0,0,0,0));
        tbl.push_back(R(0,1,1,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,2,0, 1,0,1,0,0));
        tbl.push_back(R(0,1,3,0, 1,0,1,0,0));
        tbl.push_back(R(0,0,0,1, 1,0,1,1,0));
        tbl.push_back(R(1,0,0,1, 1,0,0,0,0));
        tbl.push_back(R(0,0,0,1, 1,0,0,1,0));
        tbl.push_back(R(0,0,0,1, 1,0,0,2,0));
        tbl.push_back(R(0,0,0,0, 1,0,0,2,0));
        tbl.push_back(R(0,0,0,0, 1,0,0,2,0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].txn, tbl[i].lc);
            chk("req_ready", 66'(req_ready), 66'(tbl[i].e_rdy));
            chk("flitv", 66'(TXREQFLITV), 66'(tbl[i].e_v));
            chk("flitpend", 66'(TXREQFLITPEND), 66'(tbl[i].e_p));
            chk("crd_cnt", 66'(crd_cnt), 66'(tbl[i].e_crd));
            if (tbl[i].e_v)
                chk("flit", 66'(TXREQFLIT), 66'(mk_flit(tbl[i].e_txn)));
            if (tbl[i].rst)
                chk("crd_err_rst", 66'(crd_err), 66'(1'b0));
        end

        // C: full credit pool, six back-to-back flits
        step(1, 0, 0, 0);
        for (int k = 0; k < 15; k++) step(0, 0, 0, 1);
        chk("crd_full", 66'(crd_cnt), 66'(4'd15));
        chk("crd_err_at_max", 66'(crd_err), 66'(1'b0));
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 8'(10 + k), 0);
            chk("b2b_v", 66'(TXREQFLITV), 66'(k != 0));
            if (k != 0) chk("b2b_flit", 66'(TXREQFLIT), 66'(mk_flit(8'(9 + k))));
        end
        step(0, 0, 0, 0);
        chk("b2b_v_last", 66'(TXREQFLITV), 66'(1'b1));
        chk("b2b_flit_last", 66'(TXREQFLIT), 66'(mk_flit(8'd15)));
        chk("b2b_crd", 66'(crd_cnt), 66'(4'd9));
        chk("b2b_pend", 66'(TXREQFLITPEND), 66'(1'b0));
        step(0, 0, 0, 0);
        chk("b2b_v_end", 66'(TXREQFLITV), 66'(1'b0));

        // D: saturation and sticky error
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
        chk("sat_crd15", 66'(crd_cnt), 66'(4'd15));
        chk("sat_err_pre", 66'(crd_err), 66'(1'b0));
        step(0, 0, 0, 1);
        chk("sat_crd_hold", 66'(crd_cnt), 66'(4'd15));
        chk("sat_err", 66'(crd_err), 66'(EXP_ERR));
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("sat_err_sticky", 66'(crd_err), 66'(EXP_ERR));
        chk("sat_crd_idle", 66'(crd_cnt), 66'(4'd15));
        step(1, 0, 0, 0);
        chk("sat_err_clr", 66'(crd_err), 66'(1'b0));
        chk("sat_crd_clr", 66'(crd_cnt), 66'(4'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
